// File: rtl/reg_file_mp.sv
// Multi-port register file with reset sweep, pending-write scoreboard and optional
// same-cycle write-to-read bypass (enabled by defining REG_FILE_BYPASS_EN).
module reg_file_mp #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter int unsigned           NUM_READ   = 2,
  parameter int unsigned           NUM_WRITE  = 1,
  parameter int unsigned           SP_INDEX   = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_SP    = DATA_WIDTH'(64*1024*1024-4)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_busy,
  input  logic [NUM_WRITE-1:0]            we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic                            alloc_en,
  input  logic [ADDR_WIDTH-1:0]           alloc_addr,
  output logic                            ready
);

  localparam int unsigned           DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LAST    = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] SP_ADDR = ADDR_WIDTH'(SP_INDEX);

  typedef enum logic {INIT, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     cnt;
  logic [DEPTH-1:0]        busy;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [NUM_WRITE-1:0]    wr_valid;
  logic [ADDR_WIDTH-1:0]   wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0]   wd [NUM_WRITE];
  logic                    alloc_valid;
  logic [ADDR_WIDTH-1:0]   ra;

  always_comb begin
    wr_valid = '0;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      wa[j]       = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      wd[j]       = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      wr_valid[j] = we[j] && (wa[j] != '0);
    end
    alloc_valid = alloc_en && (alloc_addr != '0);
  end

  // Control FSM and scoreboard; alloc is applied after clears so it wins on a tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + (ADDR_WIDTH+1)'(1);
          if (cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          for (int unsigned j = 0; j < NUM_WRITE; j++)
            if (wr_valid[j]) busy[wa[j]] <= 1'b0;
          if (alloc_valid) busy[alloc_addr] <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Data array: sweep writes during INIT, port writes in READY (last port wins).
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt[ADDR_WIDTH-1:0]] <= (cnt[ADDR_WIDTH-1:0] == SP_ADDR) ? INIT_SP : '0;
      end else begin
        for (int unsigned j = 0; j < NUM_WRITE; j++)
          if (wr_valid[j]) mem[wa[j]] <= wd[j];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (ready && (ra != '0)) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
        rd_busy[i]                          = busy[ra];
`ifdef REG_FILE_BYPASS_EN
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
          if (wr_valid[j] && (wa[j] == ra)) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wd[j];
            rd_busy[i] = alloc_valid && (alloc_addr == ra);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             ready;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_ready;
  int            m_cnt;

  reg_file_mp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_READ  (NR),
    .NUM_WRITE (NW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .ready     (ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model advances on the same inputs the DUT samples at the next edge.
  task automatic tick();
    if (reset) begin
      m_ready = 0;
      m_cnt   = 0;
      for (int a = 0; a < DEPTH; a++) m_busy[a] = 0;
    end else if (!m_ready) begin
      m_regs[m_cnt] = (m_cnt == 2) ? 32'h03FF_FFFC : 32'h0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1;
    end else begin
      for (int j = 0; j < NW; j++) begin
        int a;
        a = int'(wr_addr[j*AW +: AW]);
        if (we[j] && a != 0) begin
          m_regs[a] = wr_data[j*DW +: DW];
          m_busy[a] = 0;
        end
      end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reads();
    #1;
    chk("ready", {31'b0, ready}, {31'b0, m_ready});
    for (int i = 0; i < NR; i++) begin
      int            a;
      logic [DW-1:0] ed;
      bit            eb;
      a  = int'(rd_addr[i*AW +: AW]);
      ed = '0;
      eb = 0;
      if (m_ready && a != 0) begin
        ed = m_regs[a];
        eb = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
        for (int j = 0; j < NW; j++) begin
          if (we[j] && wr_addr[j*AW +: AW] != 0 && int'(wr_addr[j*AW +: AW]) == a) begin
            ed = wr_data[j*DW +: DW];
            eb = alloc_en && (int'(alloc_addr) == a);
          end
        end
`endif
      end
      chk($sformatf("rd_data%0d@x%0d", i, a), rd_data[i*DW +: DW], ed);
      chk($sformatf("rd_busy%0d@x%0d", i, a), {31'b0, rd_busy[i]}, {31'b0, eb});
    end
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    we = '0; wr_addr = '0; wr_data = '0; alloc_en = 0; alloc_addr = '0;
  endtask

  initial begin
    reset = 1; idle(); set_rd(2, 5);
    m_ready = 0; m_cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin m_regs[a] = 'x; m_busy[a] = 0; end

    // Reset held three cycles
    repeat (3) tick();
    check_reads();
    chk("reset_ready", {31'b0, ready}, 32'h0);

    // Sweep: ready rises on exactly the 32nd edge
    reset = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      chk($sformatf("sweep_ready_e%0d", k), {31'b0, ready}, (k == DEPTH) ? 32'h1 : 32'h0);
    end
    set_rd(2, 5);
    check_reads();
    chk("x2_sp", rd_data[0 +: DW], 32'h03FF_FFFC);
    chk("x5_zero", rd_data[DW +: DW], 32'h0);
    set_rd(0, 0);
    check_reads();
    chk("x0_zero", rd_data[0 +: DW], 32'h0);

    // Mid-sweep reset restart, with pre-ready write/alloc to x3
    reset = 1; tick();
    reset = 0;
    for (int k = 1; k <= 10; k++) tick();
    reset = 1; tick();
    reset = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k == 4) begin
        we = 2'b01; wr_addr = {AW'(0), AW'(3)}; wr_data = {32'h0, 32'h77};
        alloc_en = 1; alloc_addr = 5'd3;
      end
      if (k == 5) idle();
      chk($sformatf("resweep_ready_e%0d", k), {31'b0, ready}, (k == DEPTH) ? 32'h1 : 32'h0);
    end
    set_rd(3, 2);
    check_reads();
    chk("gate_x3_data", rd_data[0 +: DW], 32'h0);
    chk("gate_x3_busy", {31'b0, rd_busy[0]}, 32'h0);

    // Same-address write conflict: port 1 wins; x0 is never written
    we = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h22, 32'h11};
    tick(); idle();
    set_rd(7, 0);
    check_reads();
    chk("conflict_x7", rd_data[0 +: DW], 32'h22);
    we = 2'b01; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'h0, 32'hFFFF_FFFF};
    tick(); idle();
    check_reads();
    chk("x0_write_ignored", rd_data[DW +: DW], 32'h0);

    // Scoreboard
    alloc_en = 1; alloc_addr = 5'd9;
    tick(); idle();
    set_rd(9, 9);
    check_reads();
    chk("alloc_busy", {31'b0, rd_busy[0]}, 32'h1);
    we = 2'b10; wr_addr = {AW'(9), AW'(0)}; wr_data = {32'hAB, 32'h0};
    tick(); idle();
    check_reads();
    chk("retire_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("retire_data", rd_data[0 +: DW], 32'hAB);
    we = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'hCD};
    alloc_en = 1; alloc_addr = 5'd9;
    tick(); idle();
    check_reads();
    chk("alloc_wins", {31'b0, rd_busy[0]}, 32'h1);

    // Same-cycle write/read of x4
    we = 2'b01; wr_addr = {AW'(0), AW'(4)}; wr_data = {32'h0, 32'h1234};
    tick(); idle();
    set_rd(4, 4);
    we = 2'b01; wr_addr = {AW'(0), AW'(4)}; wr_data = {32'h0, 32'h5A5A};
    check_reads();
`ifdef REG_FILE_BYPASS_EN
    chk("bypass_same_cycle", rd_data[0 +: DW], 32'h5A5A);
`else
    chk("no_bypass_old", rd_data[0 +: DW], 32'h1234);
`endif
    chk("bypass_busy", {31'b0, rd_busy[0]}, 32'h0);
    tick(); idle();
    check_reads();
    chk("write_visible_next", rd_data[0 +: DW], 32'h5A5A);

    // Random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 249) == 0);
      we         = NW'($urandom);
      wr_addr    = NW*AW'($urandom);
      wr_data    = {$urandom, $urandom};
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom);
      rd_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : NR*AW'($urandom);
      check_reads();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
